// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shared shift-add / restoring
// shift-subtract datapath, 32 CALC steps, sign fix-up and result register in DONE.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic             iStart,
   input  logic             iFlush,
   input  logic [2:0]       iFunct3,
   input  logic [WIDTH-1:0] iA,
   input  logic [WIDTH-1:0] iB,
   output logic             oReady,
   output logic             oBusy,
   output logic             oDone,
   output logic [WIDTH-1:0] oResult
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   typedef struct packed {
      logic [2:0] funct3;
      logic       neg;
   } op_t;

   state_t             state, state_nxt;
   op_t                op, op_in;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   opa, opb;
   logic [CW-1:0]      cnt;

   logic               a_sgn, b_sgn, a_neg, b_neg;
   logic [WIDTH-1:0]   abs_a, abs_b;
   logic               accept, last;
   logic [WIDTH:0]     mul_sum, div_r, div_diff;
   logic               div_q;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix, res_fix;

   // operand signedness and result sign, decoded from the incoming request
   always_comb begin
      a_sgn = iFunct3[2] ? ~iFunct3[0] : (iFunct3[1:0] != 2'b11);
      b_sgn = iFunct3[2] ? ~iFunct3[0] : ~iFunct3[1];
      a_neg = a_sgn & iA[WIDTH-1];
      b_neg = b_sgn & iB[WIDTH-1];
      abs_a = a_neg ? -iA : iA;
      abs_b = b_neg ? -iB : iB;
      op_in.funct3 = iFunct3;
      case (iFunct3[2:1])
         2'b11:   op_in.neg = a_neg;
         // x/0 must stay all-ones, so no negation when the divisor is zero
         2'b10:   op_in.neg = (a_neg ^ b_neg) & (iB != '0);
         default: op_in.neg = a_neg ^ b_neg;
      endcase
   end

   assign accept = (state == IDLE) & iStart & ~iFlush;
   assign last   = (cnt == CW'(WIDTH - 1));
   assign oReady = (state == IDLE);
   assign oBusy  = ~oReady;

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = CALC;
         CALC:    if (iFlush) state_nxt = IDLE;
                  else if (last) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // multiply: acc[63:32] accumulates, product shifts right, multiplier in opb.
   // divide: opa shifts dividend out MSB-first and quotient in; acc[31:0] is the remainder.
   always_comb begin
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opa & {WIDTH{opb[0]}}};
      div_r    = {acc[WIDTH-1:0], opa[WIDTH-1]};
      div_diff = div_r - {1'b0, opb};
      div_q    = ~div_diff[WIDTH];
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         op  <= '0;
         acc <= '0;
         opa <= '0;
         opb <= '0;
         cnt <= '0;
      end else if (accept) begin
         op  <= op_in;
         acc <= '0;
         opa <= abs_a;
         opb <= abs_b;
         cnt <= '0;
      end else if (state == CALC) begin
         if (op.funct3[2]) begin
            acc[WIDTH-1:0] <= div_q ? div_diff[WIDTH-1:0] : div_r[WIDTH-1:0];
            opa            <= {opa[WIDTH-2:0], div_q};
         end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
            opb <= opb >> 1;
         end
         cnt <= cnt + 1'b1;
      end
   end

   always_comb begin
      prod_fix = op.neg ? -acc : acc;
      quo_fix  = op.neg ? -opa : opa;
      rem_fix  = op.neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      case (op.funct3)
         3'b000:                res_fix = prod_fix[WIDTH-1:0];
         3'b001, 3'b010, 3'b011: res_fix = prod_fix[2*WIDTH-1:WIDTH];
         3'b100, 3'b101:        res_fix = quo_fix;
         default:               res_fix = rem_fix;
      endcase
   end

   // a flush in DONE suppresses both the pulse and the result update
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         oDone   <= 1'b0;
         oResult <= '0;
      end else begin
         oDone <= 1'b0;
         if (state == DONE && !iFlush) begin
            oDone   <= 1'b1;
            oResult <= res_fix;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed + randomized bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
   logic        iCLK = 1'b0, iRST = 1'b1, iStart = 1'b0, iFlush = 1'b0;
   logic [2:0]  iFunct3 = '0;
   logic [31:0] iA = '0, iB = '0;
   logic        oReady, oBusy, oDone;
   logic [31:0] oResult;

   int checks = 0, failures = 0;
   int cyc = 0, acc_cyc = 0;
   logic prev_done = 1'b0;

   muldiv_unit #(.WIDTH(32)) dut (
      .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iFlush(iFlush),
      .iFunct3(iFunct3), .iA(iA), .iB(iB),
      .oReady(oReady), .oBusy(oBusy), .oDone(oDone), .oResult(oResult)
   );

   always #5 iCLK = ~iCLK;
   always @(posedge iCLK) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   always @(negedge iCLK) begin
      chk("ready_not_busy", {31'b0, oReady}, {31'b0, ~oBusy});
      if (oDone) chk("done_single_cycle", {31'b0, prev_done}, 32'd0);
      prev_done <= oDone;
   end

   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sb;
      longint unsigned ua, ub;
      logic [63:0] p;
      logic [31:0] r;
      logic ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = 64'(a);
      ub  = 64'(b);
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      r   = '0;
      p   = '0;
      case (f)
         3'd0: begin p = sa * sb; r = p[31:0]; end
         3'd1: begin p = sa * sb; r = p[63:32]; end
         3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
         3'd3: begin p = ua * ub; r = p[63:32]; end
         3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
         3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: r = (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
         default: r = (b == 0) ? a : a % b;
      endcase
      return r;
   endfunction

   task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      @(negedge iCLK);
      iFunct3 = f; iA = a; iB = b; iStart = 1'b1;
      @(posedge iCLK);
      #1;
      acc_cyc = cyc;
      iStart  = 1'b0;
      iA      = $urandom;
      iB      = $urandom;
      iFunct3 = 3'($urandom);
   endtask

   task automatic wait_done(output logic [31:0] res, output int lat);
      while (!oDone && (cyc - acc_cyc) < 100) begin
         @(posedge iCLK);
         #1;
      end
      lat = cyc - acc_cyc;
      res = oResult;
   endtask

   task automatic run(input string tag, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] b);
      logic [31:0] res;
      int lat;
      start_op(f, a, b);
      wait_done(res, lat);
      chk({tag, "_result"}, res, model(f, a, b));
      chk({tag, "_latency"}, 32'(lat), 32'd33);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'($urandom_range(0, 100));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [31:0] res, last_exp;
      int lat, nd, t0, quiet;
      int dc [3];

      repeat (2) @(negedge iCLK);
      chk("rst_ready", {31'b0, oReady}, 32'd1);
      chk("rst_busy", {31'b0, oBusy}, 32'd0);
      chk("rst_done", {31'b0, oDone}, 32'd0);
      chk("rst_result", oResult, 32'd0);
      @(negedge iCLK);
      iRST = 1'b0;

      run("mul_7x-3", 3'b000, 32'd7, 32'hFFFF_FFFD);
      chk("mul_7x-3_const", oResult, 32'hFFFF_FFEB);
      run("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000);
      chk("mulh_const", oResult, 32'h4000_0000);
      run("mulhu", 3'b011, 32'h8000_0000, 32'h8000_0000);
      chk("mulhu_const", oResult, 32'h4000_0000);
      run("mulhsu", 3'b010, 32'h8000_0000, 32'h8000_0000);
      chk("mulhsu_const", oResult, 32'hC000_0000);
      run("div_-7_2", 3'b100, 32'hFFFF_FFF9, 32'd2);
      chk("div_-7_2_const", oResult, 32'hFFFF_FFFD);
      run("rem_-7_2", 3'b110, 32'hFFFF_FFF9, 32'd2);
      chk("rem_-7_2_const", oResult, 32'hFFFF_FFFF);
      run("divu_20_6", 3'b101, 32'd20, 32'd6);
      chk("divu_20_6_const", oResult, 32'd3);
      run("divu_by0", 3'b101, 32'd55, 32'd0);
      chk("divu_by0_const", oResult, 32'hFFFF_FFFF);
      run("remu_by0", 3'b111, 32'h1234, 32'd0);
      chk("remu_by0_const", oResult, 32'h1234);
      run("div_by0", 3'b100, 32'hFFFF_FFF0, 32'd0);
      run("rem_by0", 3'b110, 32'hFFFF_FFF0, 32'd0);
      run("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
      chk("div_ovf_const", oResult, 32'h8000_0000);
      run("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
      chk("rem_ovf_const", oResult, 32'd0);

      // start while busy is ignored
      start_op(3'b100, 32'd100, 32'd7);
      chk("busy_after_accept", {31'b0, oBusy}, 32'd1);
      repeat (10) @(posedge iCLK);
      @(negedge iCLK);
      iFunct3 = 3'b000; iA = 32'd5; iB = 32'd9; iStart = 1'b1;
      @(negedge iCLK);
      iStart = 1'b0;
      wait_done(res, lat);
      chk("ignored_start_result", res, 32'd14);
      chk("ignored_start_latency", 32'(lat), 32'd33);

      // held start: completions spaced by the 34-cycle issue interval
      @(negedge iCLK);
      iFunct3 = 3'b000; iA = 32'd3; iB = 32'd5; iStart = 1'b1;
      t0 = cyc; nd = 0; dc = '{0, 0, 0};
      while (nd < 3 && (cyc - t0) < 200) begin
         @(posedge iCLK);
         #1;
         if (oDone) begin
            dc[nd] = cyc;
            chk("held_start_result", oResult, 32'd15);
            nd++;
            if (nd == 3) iStart = 1'b0;
         end
      end
      iStart = 1'b0;
      chk("held_first_latency", 32'(dc[0] - t0), 32'd34);
      chk("held_spacing_1", 32'(dc[1] - dc[0]), 32'd34);
      chk("held_spacing_2", 32'(dc[2] - dc[1]), 32'd34);
      last_exp = 32'd15;

      // flush and start together in IDLE: start dropped
      @(negedge iCLK);
      iStart = 1'b1; iFlush = 1'b1;
      @(posedge iCLK);
      #1;
      chk("flush_beats_start", {31'b0, oReady}, 32'd1);
      iStart = 1'b0; iFlush = 1'b0;

      // flush mid-CALC
      start_op(3'b001, 32'h1234_5678, 32'h9ABC_DEF0);
      repeat (14) @(posedge iCLK);
      @(negedge iCLK);
      iFlush = 1'b1;
      @(posedge iCLK);
      #1;
      chk("flush_to_idle", {31'b0, oReady}, 32'd1);
      iFlush = 1'b0;
      quiet = 0;
      repeat (40) begin
         @(posedge iCLK);
         #1;
         if (oDone) quiet++;
      end
      chk("flush_no_done", 32'(quiet), 32'd0);
      chk("flush_result_kept", oResult, last_exp);

      // async reset mid-CALC
      start_op(3'b100, 32'd1000, 32'd3);
      repeat (10) @(posedge iCLK);
      @(negedge iCLK);
      iRST = 1'b1;
      #1;
      chk("arst_ready", {31'b0, oReady}, 32'd1);
      chk("arst_busy", {31'b0, oBusy}, 32'd0);
      chk("arst_done", {31'b0, oDone}, 32'd0);
      chk("arst_result", oResult, 32'd0);
      @(negedge iCLK);
      iRST = 1'b0;
      run("after_rst", 3'b110, 32'd1000, 32'd3);

      for (int i = 0; i < 48; i++) begin
         run("rand", 3'($urandom_range(0, 7)), pick(), pick());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
